// File: rtl/ifetch_stage.sv
// DLX instruction-fetch stage: PC register, IF/ID pipeline register and
// ID-stage jump/branch resolution with a one-slot squash on redirect.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] IAddr,
  input  logic [31:0] IData,
  input  logic        IReady,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic [1:0]  JumpType,
  input  logic        CondSrc,
  input  logic        BranchCond,
  input  logic [31:0] RegA,
  input  logic        FPSR,
  input  logic [31:0] IAR,
  output logic [31:0] IDInstr,
  output logic [31:0] IDPC4,
  output logic        IDValid,
  output logic        Redirect
);

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        cond_s;
  logic        taken_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] imm16_s;
  logic [31:0] imm26_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;

  // DLX bit 31 is the LSB, so Imm16/Imm26 are the low-order fields here.
  assign imm16_s    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm26_s    = {{6{instr_q[25]}}, instr_q[25:0]};
  assign pc_plus4_s = pc_q + 32'd4;

  assign cond_s  = CondSrc ? (RegA == 32'h0000_0000) : FPSR;
  assign taken_s = valid_q & ~Stall & (Jump | (Branch & (cond_s == BranchCond)));

  // Control-transfer target selection
  always_comb begin
    target_raw_s = RegA;
    case (JumpType)
      2'b00:   target_raw_s = RegA;
      2'b01:   target_raw_s = pc4_q + imm16_s;
      2'b10:   target_raw_s = pc4_q + imm26_s;
      2'b11:   target_raw_s = IAR;
      default: target_raw_s = RegA;
    endcase
  end

  assign target_s = target_raw_s & 32'hFFFF_FFFC;

  // Next-state: stall, then redirect, then fetch, then wait state
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (Stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (taken_s) begin
      pc_d    = target_s;
      instr_d = NOP_INSTR;
      pc4_d   = pc4_q;
      valid_d = 1'b0;
    end else if (IReady) begin
      pc_d    = pc_plus4_s;
      instr_d = IData;
      pc4_d   = pc_plus4_s;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
      instr_d = NOP_INSTR;
      pc4_d   = pc4_q;
      valid_d = 1'b0;
    end
  end

  // PC and IF/ID state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC_A;
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC_A;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign IAddr    = pc_q;
  assign IDInstr  = instr_q;
  assign IDPC4    = pc4_q;
  assign IDValid  = valid_q;
  assign Redirect = taken_s;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage; the instruction memory
// returns 0xA000_0000 | address unless a specific word is overridden.
module tb_ifetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] IAddr;
  logic [31:0] IData;
  logic        IReady;
  logic        Stall;
  logic        Jump;
  logic        Branch;
  logic [1:0]  JumpType;
  logic        CondSrc;
  logic        BranchCond;
  logic [31:0] RegA;
  logic        FPSR;
  logic [31:0] IAR;
  logic [31:0] IDInstr;
  logic [31:0] IDPC4;
  logic        IDValid;
  logic        Redirect;

  logic        ovr_en;
  logic [31:0] ovr_word;
  int          n_tests;
  int          n_fail;

  ifetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IAddr     (IAddr),
    .IData     (IData),
    .IReady    (IReady),
    .Stall     (Stall),
    .Jump      (Jump),
    .Branch    (Branch),
    .JumpType  (JumpType),
    .CondSrc   (CondSrc),
    .BranchCond(BranchCond),
    .RegA      (RegA),
    .FPSR      (FPSR),
    .IAR       (IAR),
    .IDInstr   (IDInstr),
    .IDPC4     (IDPC4),
    .IDValid   (IDValid),
    .Redirect  (Redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    IData = ovr_en ? ovr_word : (32'hA000_0000 | IAddr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    Stall = 1'b0; Jump = 1'b0; Branch = 1'b0; JumpType = 2'b00;
    CondSrc = 1'b0; BranchCond = 1'b0; RegA = 32'h0; FPSR = 1'b0;
    IAR = 32'h0; ovr_en = 1'b0;
  endtask

  task automatic check_if(input string tag, input logic [31:0] a, input logic [31:0] ins,
                          input logic [31:0] pc4, input logic v);
    check_eq({tag, ".IAddr"}, IAddr, a);
    check_eq({tag, ".IDInstr"}, IDInstr, ins);
    check_eq({tag, ".IDPC4"}, IDPC4, pc4);
    check_eq({tag, ".IDValid"}, {31'h0, IDValid}, {31'h0, v});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ovr_word = 32'h0;
    clear_ctl();
    IReady = 1'b1;
    reset  = 1'b1;
    #1;
    check_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("rst.Redirect", {31'h0, Redirect}, 32'h0);
    #11 reset = 1'b0;

    // Sequential fetch W0..W3
    tick(); check_if("seq0", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    tick(); check_if("seq1", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
    tick(); check_if("seq2", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
    tick(); check_eq("seq3.IAddr", IAddr, 32'h10);

    // BEQZ taken back to 0x04
    ovr_en = 1'b1; ovr_word = 32'h1000_FFF0;
    tick(); ovr_en = 1'b0;
    check_if("beqz.id", 32'h14, 32'h1000_FFF0, 32'h14, 1'b1);
    Branch = 1'b1; CondSrc = 1'b1; BranchCond = 1'b1; JumpType = 2'b01; RegA = 32'h0;
    #1 check_eq("beqz.Redirect", {31'h0, Redirect}, 32'h1);
    tick(); check_if("beqz.tgt", 32'h4, 32'h0, 32'h14, 1'b0);
    check_eq("bubble.noRedirect", {31'h0, Redirect}, 32'h0);
    clear_ctl();
    tick(); tick(); tick();
    check_eq("beqz2.pc", IAddr, 32'h10);
    ovr_en = 1'b1; ovr_word = 32'h1000_FFF0;
    tick(); ovr_en = 1'b0;
    Branch = 1'b1; CondSrc = 1'b1; BranchCond = 1'b1; JumpType = 2'b01; RegA = 32'h5;
    #1 check_eq("beqz2.Redirect", {31'h0, Redirect}, 32'h0);
    tick(); check_if("beqz2.nt", 32'h18, 32'hA000_0014, 32'h18, 1'b1);

    // BFPF: Imm16=0x14, target 0x18+0x14
    Branch = 1'b1; CondSrc = 1'b0; BranchCond = 1'b0; JumpType = 2'b01; RegA = 32'h0; FPSR = 1'b1;
    #1 check_eq("bfpf.fpsr1", {31'h0, Redirect}, 32'h0);
    FPSR = 1'b0;
    #1 check_eq("bfpf.fpsr0", {31'h0, Redirect}, 32'h1);
    tick(); check_if("bfpf.tgt", 32'h2C, 32'h0, 32'h18, 1'b0);
    clear_ctl();

    // JR with unaligned RegA
    tick(); check_if("jr.id", 32'h30, 32'hA000_002C, 32'h30, 1'b1);
    Jump = 1'b1; JumpType = 2'b00; RegA = 32'h0000_1003;
    tick(); check_eq("jr.tgt", IAddr, 32'h0000_1000);
    clear_ctl();

    // J (Imm26=0x40) stalled three cycles
    ovr_en = 1'b1; ovr_word = 32'h0800_0040;
    tick(); ovr_en = 1'b0;
    check_if("j.id", 32'h1004, 32'h0800_0040, 32'h1004, 1'b1);
    Jump = 1'b1; JumpType = 2'b10; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall.Redirect", {31'h0, Redirect}, 32'h0);
      tick(); check_if("stall.hold", 32'h1004, 32'h0800_0040, 32'h1004, 1'b1);
    end
    Stall = 1'b0;
    #1 check_eq("stall.release", {31'h0, Redirect}, 32'h1);
    tick(); check_if("j.tgt", 32'h1044, 32'h0, 32'h1004, 1'b0);
    clear_ctl();

    // Wait states at 0x20
    tick();
    Jump = 1'b1; JumpType = 2'b00; RegA = 32'h20;
    tick(); clear_ctl(); IReady = 1'b0;
    check_eq("ws.pc0", IAddr, 32'h20);
    tick(); check_eq("ws1.IAddr", IAddr, 32'h20);
    check_eq("ws1.IDValid", {31'h0, IDValid}, 32'h0);
    tick(); check_eq("ws2.IAddr", IAddr, 32'h20);
    check_eq("ws2.IDValid", {31'h0, IDValid}, 32'h0);
    IReady = 1'b1;
    tick(); check_if("ws.resume", 32'h24, 32'hA000_0020, 32'h24, 1'b1);

    // RFE while IReady=0
    IReady = 1'b0; Jump = 1'b1; JumpType = 2'b11; IAR = 32'h300;
    tick(); check_if("rfe.tgt", 32'h300, 32'h0, 32'h24, 1'b0);
    clear_ctl(); IReady = 1'b1;

    // Async reset during a redirect
    tick();
    Jump = 1'b1; JumpType = 2'b00; RegA = 32'h5000;
    #1 check_eq("rr.Redirect", {31'h0, Redirect}, 32'h1);
    #1 reset = 1'b1;
    #1 check_if("rr.reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("rr.Redirect0", {31'h0, Redirect}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0; clear_ctl();
    tick(); check_if("rr.first", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

    // PC wrap
    Jump = 1'b1; JumpType = 2'b00; RegA = 32'hFFFF_FFFC;
    tick(); check_eq("wrap.tgt", IAddr, 32'hFFFF_FFFC);
    clear_ctl();
    tick(); check_if("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined DLX core. It holds the PC, drives the instruction-memory address, and latches each fetched word plus PC+4 into IF/ID. It resolves jumps and branches in ID using the decoder's JumpType/CondSrc/BranchCond and the register-read value, and redirects the PC with a one-slot squash. It also absorbs hazard stalls and instruction-memory wait states.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- IAddr  out  32  instruction-memory address, equal to PC.
- IData  in  32  instruction word for IAddr, valid in the same cycle when IReady=1.
- IReady  in  1  instruction memory has IData valid this cycle.
- Stall  in  1  hazard hold from ID: freeze PC and IF/ID.
- Jump  in  1  ID instruction is an unconditional jump (J/JAL/JR/JALR/RFE/TRAP class).
- Branch  in  1  ID instruction is a conditional branch.
- JumpType  in  2  target select: 00 RegA, 01 IDPC4+sext(Imm16), 10 IDPC4+sext(Imm26), 11 IAR.
- CondSrc  in  1  1 = RegA zero test, 0 = FPSR.
- BranchCond  in  1  branch taken when the tested condition equals this bit.
- RegA  in  32  GPR rs1 value read in ID, already forwarded.
- FPSR  in  1  FP status bit.
- IAR  in  32  interrupt address register value.
- IDInstr  out  32  IF/ID instruction register.
- IDPC4  out  32  IF/ID PC+4 register.
- IDValid  out  1  IF/ID holds a real instruction, not a bubble.
- Redirect  out  1  combinational: a taken control transfer is being applied this cycle.

## Operation
- Cond = CondSrc ? (RegA == 0) : FPSR.
- Taken = IDValid & ~Stall & (Jump | (Branch & (Cond == BranchCond))).
- Redirect = Taken.
- Imm16 = IDInstr[16:31] and Imm26 = IDInstr[6:31], both sign-extended to 32 bits. Sums use 32-bit modulo arithmetic.
- Target is selected by JumpType. Target[30:31] are forced to 00, and PC[30:31] is always 00.
- Next-state priority, first match wins:
  1. Stall=1: PC, IDInstr, IDPC4 and IDValid hold. IReady is ignored.
  2. Taken: PC <= Target; IDInstr <= NOP_INSTR; IDValid <= 0. The word fetched this cycle is squashed, whatever IReady is.
  3. IReady=1: PC <= PC+4; IDInstr <= IData; IDPC4 <= PC+4; IDValid <= 1.
  4. IReady=0: PC holds; IDInstr <= NOP_INSTR; IDValid <= 0; IDPC4 holds.
- Jump/Branch/JumpType/CondSrc/BranchCond/RegA are only meaningful while IDValid=1. A bubble never redirects.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Link values (JAL r31 = IDPC4) are taken downstream from IDPC4. This block does not write registers.

## Timing
- Reset asserted: PC=RESET_PC, IDInstr=NOP_INSTR, IDPC4=RESET_PC, IDValid=0, immediately (async). Redirect=0 follows combinationally.
- Reset mid-operation discards any in-flight redirect or stall state. The first fetch after deassertion is from RESET_PC.
- IAddr is a register output with no combinational path from IData, IReady or the decode inputs.
- Fetch latency: an instruction is at IAddr in cycle N and in IDInstr in cycle N+1 when IReady=1 and Stall=0.
- Control-transfer penalty: exactly one bubble. The branch sits in ID in cycle N, the target is at IAddr in cycle N+1, and IDValid=0 in cycle N+1.
- Redirect is combinational from the ID inputs and is valid in the same cycle.
- Stall and a taken branch in the same cycle: the stall wins. The redirect is re-evaluated on the first unstalled cycle using the then-current RegA/FPSR.
- IReady=0 and Taken in the same cycle: the redirect is applied and the memory request at the old PC is abandoned.

## Test plan
- Reset, then IReady=1 with words W0..W3: IAddr steps 0,4,8,C. IDInstr=W0 one cycle after IAddr=0, with IDPC4=4 and IDValid=1.
- BEQZ at PC=0x10 (Branch=1, CondSrc=1, BranchCond=1, JumpType=01, Imm16=0xFFF0, RegA=0): Redirect=1, next IAddr=0x04, and the following IDValid=0. Repeat with RegA=5: no redirect, IAddr continues 0x18.
- BFPF (CondSrc=0, BranchCond=0) with FPSR=0 is taken; with FPSR=1 it is not taken. JR with RegA=0x0000_1003 gives next IAddr=0x0000_1000.
- Stall held 3 cycles while a taken J (JumpType=10, Imm26=0x40) is in ID: PC and IF/ID are frozen and Redirect=0. On the release cycle, Redirect=1 and next IAddr=IDPC4+0x40.
- IReady=0 for 2 cycles at PC=0x20: IAddr stays 0x20 and IDValid=0 both cycles. With IReady=0 and a taken RFE (JumpType=11, IAR=0x300), next IAddr=0x300.
- Assert reset asynchronously mid-cycle during a redirect: outputs return to reset values before the next clk edge. Also check PC wrap from 0xFFFF_FFFC to 0x0.
